// File: rtl/alu_op_sequencer.sv
// Moore control unit sequencing fetch plus one register-register ALU instruction for the Datapath.
// Latency: start sampled at edge E -> done in cycle E+7 (normal op) or E+8 (MUL/DIV), +1 per T1 wait cycle.
// Backpressure: T1 holds until mem_ready; after TIMEOUT+1 unready cycles the sequence aborts with err. start is ignored when busy.
module alu_op_sequencer #(
  parameter logic [4:0] OP_MUL  = 5'b01111,
  parameter logic [4:0] OP_DIV  = 5'b10000,
  parameter logic [4:0] OP_MAX  = 5'b10100,
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        Clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhiout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic [4:0]  IRout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ERR
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;

  // Instruction fields; only meaningful once IRin has loaded ir at the T2 edge.
  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_muldiv;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_muldiv    = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_unused_ir = ^ir[14:0];

  // State register and T1 wait counter; Clear dominates everything, including start.
  always_ff @(posedge clk) begin
    if (Clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_T0;
            r_cnt   <= 4'd0;
          end
        end
        S_T0: r_state <= S_T1;
        S_T1: begin
          // Data arriving on the last allowed cycle still wins over the abort.
          if (mem_ready) begin
            r_state <= S_T2;
          end else if (r_cnt == TIMEOUT) begin
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= (w_op > OP_MAX) ? S_ERR : S_T4;
        S_T4:    r_state <= S_T5;
        S_T5:    r_state <= w_muldiv ? S_T6 : S_DONE;
        S_T6:    r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from the current state; register selects come from the loaded IR fields.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    Zhiout  = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    HIin    = 1'b0;
    LOin    = 1'b0;
    reg_in  = 16'd0;
    reg_out = 16'd0;
    IRout   = 5'd0;
    busy    = (r_state != S_IDLE);
    done    = 1'b0;
    err     = 1'b0;
    case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = (r_cnt == 4'd0);
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        reg_out = 16'd1 << w_rb;
        Yin     = 1'b1;
      end
      S_T4: begin
        reg_out = 16'd1 << w_rc;
        IRout   = w_op;
        Zin     = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        IRout   = w_op;
        if (w_muldiv) begin
          LOin = 1'b1;
        end else begin
          reg_in = 16'd1 << w_ra;
        end
      end
      S_T6: begin
        Zhiout = 1'b1;
        HIin   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: per-cycle comparison of every output against an expected trace.
// The trace is built from the instruction's step list (fetch, wait, decode, execute, retire).
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic        pcout, zlowout, zhiout, mdrout, marin, pcin, incpc, read, mdrin, irin, yin, zin, hiin, loin;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic [4:0]  irout;
    logic        busy, done, err;
  } out_t;

  localparam logic [4:0] MUL  = 5'b01111;
  localparam logic [4:0] DIV  = 5'b10000;
  localparam int         MAXOP = 20;
  localparam int         TMO   = 15;
  localparam int         NEVER = 1000;

  logic        clk = 1'b0;
  logic        Clear, start, mem_ready;
  logic [31:0] ir;
  logic        PCout, Zlowout, Zhiout, MDRout, MARin, PCin, IncPC, Read, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  IRout;
  logic        busy, done, err;

  out_t obs;
  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .Clear(Clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .Zhiout(Zhiout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .reg_in(reg_in), .reg_out(reg_out), .IRout(IRout),
    .busy(busy), .done(done), .err(err)
  );

  assign obs = {PCout, Zlowout, Zhiout, MDRout, MARin, PCin, IncPC, Read, MDRin, IRin, Yin, Zin, HIin, LOin,
                reg_in, reg_out, IRout, busy, done, err};

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [3:0] rc);
    logic [14:0] low;
    low = 15'($urandom);
    return {op, ra, rb, rc, low};
  endfunction

  // Expected cycle-by-cycle outputs from T0 up to and including the retire/abort cycle.
  // waits = number of T1 cycles with mem_ready low before it rises.
  task automatic build_trace(input logic [31:0] ir_v, input int waits);
    out_t e;
    int   op, ra, rb, rc, n_t1;
    logic md;
    op = int'(ir_v[31:27]);
    ra = int'(ir_v[26:23]);
    rb = int'(ir_v[22:19]);
    rc = int'(ir_v[18:15]);
    md = (ir_v[31:27] == MUL) || (ir_v[31:27] == DIV);
    exp_q.delete();
    e = '0; e.busy = 1; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
    exp_q.push_back(e);
    n_t1 = (waits > TMO) ? TMO + 1 : waits + 1;
    for (int i = 0; i < n_t1; i++) begin
      e = '0; e.busy = 1; e.zlowout = 1; e.read = 1; e.mdrin = 1; e.pcin = (i == 0);
      exp_q.push_back(e);
    end
    if (waits > TMO) begin
      e = '0; e.busy = 1; e.err = 1;
      exp_q.push_back(e);
      return;
    end
    e = '0; e.busy = 1; e.mdrout = 1; e.irin = 1;
    exp_q.push_back(e);
    e = '0; e.busy = 1; e.reg_out[rb] = 1'b1; e.yin = 1;
    exp_q.push_back(e);
    if (op > MAXOP) begin
      e = '0; e.busy = 1; e.err = 1;
      exp_q.push_back(e);
      return;
    end
    e = '0; e.busy = 1; e.reg_out[rc] = 1'b1; e.irout = 5'(op); e.zin = 1;
    exp_q.push_back(e);
    e = '0; e.busy = 1; e.zlowout = 1; e.irout = 5'(op);
    if (md) e.loin = 1;
    else    e.reg_in[ra] = 1'b1;
    exp_q.push_back(e);
    if (md) begin
      e = '0; e.busy = 1; e.zhiout = 1; e.hiin = 1;
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1; e.done = 1;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    total++;
    if (obs !== out_t'(0)) begin
      bad++;
      $display("FAIL %s idle: got %h want %h", tag, obs, out_t'(0));
    end
  endtask

  // One full instruction: start pulse, random start noise while busy, mem_ready after `waits` T1 cycles.
  task automatic run_instr(input logic [31:0] ir_v, input int waits, input string tag, input int exp_len);
    build_trace(ir_v, waits);
    total++;
    if (exp_len > 0 && exp_q.size() != exp_len) begin
      bad++;
      $display("FAIL %s trace length: got %0d want %0d", tag, exp_q.size(), exp_len);
    end
    ir        = ir_v;
    start     = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      if (k < 2) mem_ready = 1'($urandom_range(0, 1));
      else       mem_ready = ((k - 2) >= waits);
      @(negedge clk);
      total++;
      if (obs !== exp_q[k-1]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", tag, k, obs, exp_q[k-1]);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check_idle(tag);
  endtask

  task automatic test_reset();
    Clear = 1'b1; start = 1'b1; mem_ready = 1'b0; ir = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (obs !== out_t'(0)) begin
        bad++;
        $display("FAIL reset cycle %0d: got %h want %h", i, obs, out_t'(0));
      end
    end
    @(posedge clk);
    #1;
    Clear = 1'b0; start = 1'b0;
    check_idle("reset_release");
    @(posedge clk);
    #1;
    check_idle("idle_hold");
  endtask

  task automatic test_normal();
    // SHRA R2 <- R1 >> R3: T0..T5 then done, 7 cycles from the start edge.
    run_instr(mk_ir(5'b10010, 4'd2, 4'd1, 4'd3), 0, "shra", 7);
    run_instr(mk_ir(5'b00011, 4'd15, 4'd14, 4'd0), 0, "add_r15", 7);
  endtask

  task automatic test_muldiv();
    run_instr(mk_ir(MUL, 4'd7, 4'd4, 4'd5), 0, "mul", 8);
    run_instr(mk_ir(DIV, 4'd0, 4'd9, 4'd10), 0, "div", 8);
  endtask

  task automatic test_mem_wait();
    run_instr(mk_ir(5'b00100, 4'd6, 4'd2, 4'd8), 3, "wait3", 10);
    run_instr(mk_ir(5'b00100, 4'd6, 4'd2, 4'd8), TMO, "wait_last", 7 + TMO);
    run_instr(mk_ir(5'b00100, 4'd6, 4'd2, 4'd8), NEVER, "timeout", TMO + 3);
  endtask

  task automatic test_illegal();
    run_instr(mk_ir(5'b11111, 4'd3, 4'd5, 4'd6), 0, "illegal", 5);
    run_instr(mk_ir(5'b10101, 4'd3, 4'd5, 4'd6), 1, "illegal_21", 6);
    run_instr(mk_ir(5'b10100, 4'd3, 4'd5, 4'd6), 0, "opmax", 7);
  endtask

  task automatic test_same_regs();
    run_instr(mk_ir(5'b00011, 4'd0, 4'd0, 4'd0), 0, "r0_all", 7);
    run_instr(mk_ir(5'b00101, 4'd11, 4'd11, 4'd11), 2, "r11_all", 9);
  endtask

  task automatic test_clear_mid();
    logic [31:0] v;
    v = mk_ir(5'b00011, 4'd2, 4'd1, 4'd3);
    build_trace(v, 0);
    ir = v; start = 1'b1; mem_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== exp_q[k-1]) begin
        bad++;
        $display("FAIL clear_mid pre cycle %0d: got %h want %h", k, obs, exp_q[k-1]);
      end
    end
    // Still in T4 here; Clear lands at the next edge.
    Clear = 1'b1;
    @(posedge clk);
    #1;
    Clear = 1'b0;
    check_idle("clear_mid_abort");
    @(posedge clk);
    #1;
    check_idle("clear_mid_gap");
    run_instr(v, 0, "clear_mid_restart", 7);
  endtask

  task automatic test_random();
    logic [4:0] op;
    int         w, r;
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      op = MUL;
      else if (r == 1) op = DIV;
      else             op = 5'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 6)       w = int'($urandom_range(0, 3));
      else if (r == 6) w = TMO;
      else if (r == 7) w = NEVER;
      else             w = 0;
      run_instr(mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)), w, "random", 0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_muldiv();
    test_mem_wait();
    test_illegal();
    test_same_regs();
    test_clear_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
